// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for the buffered immediate extender: producer-side instruction
// stream in, consumer-side extended-immediate stream out, plus occupancy.
interface imm_extend_pipe_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             in_instr;
    logic [2:0]              in_func;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         out_imm;
    logic                    out_err;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output in_valid, in_instr, in_func, out_ready,
        input  in_ready, out_valid, out_imm, out_err, count
    );

    modport slave (
        input  in_valid, in_instr, in_func, out_ready,
        output in_ready, out_valid, out_imm, out_err, count
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// RISC-V immediate extender with a DEPTH-entry result FIFO so decode can run
// ahead of a stalled consumer.
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    imm_extend_pipe_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    function automatic logic [XLEN-1:0] ext_imm(input logic [31:7] instr,
                                                 input logic [2:0]  func);
        logic signed [31:0] v;
        logic [XLEN-1:0]    r;
        v = '0;
        r = '0;
        case (func)
            3'b000: v = 32'($signed(instr[31:20]));
            3'b001: v = 32'($signed({instr[31:25], instr[11:7]}));
            3'b010: v = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            3'b011: v = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            3'b100: v = $signed({instr[31:12], 12'b0});
            default: v = '0;
        endcase
        // Signed size cast sign-extends the 32-bit result to XLEN.
        r = XLEN'(v);
        if (func == 3'b101) r = XLEN'(instr[19:15]);
        if (func == 3'b110) r = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
        return r;
    endfunction

    logic [XLEN-1:0] imm_mem_q [DEPTH];
    logic            err_mem_q [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [XLEN-1:0] last_imm_q, last_imm_d;
    logic            last_err_q, last_err_d;

    logic            full, empty, push, pop;
    logic [XLEN-1:0] new_imm;
    logic            new_err;
    logic            unused_instr;

    assign unused_instr = ^bus.in_instr[6:0];

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = bus.in_valid && !full;
    assign pop     = !empty && bus.out_ready;
    assign new_imm = ext_imm(bus.in_instr[31:7], bus.in_func);
    assign new_err = (bus.in_func == 3'b111);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        last_imm_d = last_imm_q;
        last_err_d = last_err_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            last_imm_d = imm_mem_q[rd_ptr_q];
            last_err_d = err_mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_imm_q <= '0;
            last_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_imm_q <= last_imm_d;
            last_err_q <= last_err_d;
        end
    end

    // Storage is intentionally unreset; only occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            imm_mem_q[wr_ptr_q] <= new_imm;
            err_mem_q[wr_ptr_q] <= new_err;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.count     = count_q;
    assign bus.out_imm   = empty ? last_imm_q : imm_mem_q[rd_ptr_q];
    assign bus.out_err   = empty ? last_err_q : err_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances, both DEPTH=2.
module tb_imm_extend_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.XLEN(32), .DEPTH(2)) b32 ();
    imm_extend_pipe_if #(.XLEN(64), .DEPTH(2)) b64 ();

    imm_extend_pipe #(.XLEN(32), .DEPTH(2)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    imm_extend_pipe #(.XLEN(64), .DEPTH(2)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one word into an empty FIFO, check the head, then pop it.
    task automatic xfer(input bit w64, input logic [31:0] instr, input logic [2:0] func,
                        input logic [63:0] exp_imm, input logic exp_err, input string tag);
        if (w64) begin
            b64.in_valid = 1'b1; b64.in_instr = instr; b64.in_func = func; b64.out_ready = 1'b0;
        end else begin
            b32.in_valid = 1'b1; b32.in_instr = instr; b32.in_func = func; b32.out_ready = 1'b0;
        end
        step();
        if (w64) begin
            b64.in_valid = 1'b0;
            chk({tag, "_vld"}, 64'(b64.out_valid), 64'd1);
            chk({tag, "_imm"}, b64.out_imm, exp_imm);
            chk({tag, "_err"}, 64'(b64.out_err), 64'(exp_err));
            b64.out_ready = 1'b1;
        end else begin
            b32.in_valid = 1'b0;
            chk({tag, "_vld"}, 64'(b32.out_valid), 64'd1);
            chk({tag, "_imm"}, 64'(b32.out_imm), exp_imm);
            chk({tag, "_err"}, 64'(b32.out_err), 64'(exp_err));
            b32.out_ready = 1'b1;
        end
        step();
        b32.out_ready = 1'b0;
        b64.out_ready = 1'b0;
        chk({tag, "_cnt0"}, w64 ? 64'(b64.count) : 64'(b32.count), 64'd0);
    endtask

    initial begin
        b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_func = '0; b32.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_func = '0; b64.out_ready = 1'b0;
        #12;
        chk("rst_vld",   64'(b32.out_valid), 64'd0);
        chk("rst_rdy",   64'(b32.in_ready),  64'd1);
        chk("rst_cnt",   64'(b32.count),     64'd0);
        chk("rst_imm",   64'(b32.out_imm),   64'd0);
        chk("rst_err",   64'(b32.out_err),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // I then B queued, first result visible one cycle after its push
        b32.in_valid = 1'b1; b32.in_instr = 32'hFFF00093; b32.in_func = 3'b000;
        step();
        chk("i_vld", 64'(b32.out_valid), 64'd1);
        chk("i_imm", 64'(b32.out_imm),   64'hFFFFFFFF);
        chk("i_err", 64'(b32.out_err),   64'd0);
        b32.in_instr = 32'hFE000CE3; b32.in_func = 3'b010;
        step();
        b32.in_valid = 1'b0;
        chk("ib_cnt", 64'(b32.count), 64'd2);
        chk("ib_head", 64'(b32.out_imm), 64'hFFFFFFFF);
        b32.out_ready = 1'b1;
        step();
        chk("b_imm", 64'(b32.out_imm), 64'hFFFFFFF8);
        chk("b_err", 64'(b32.out_err), 64'd0);
        chk("b_cnt", 64'(b32.count),   64'd1);
        step();
        b32.out_ready = 1'b0;
        chk("ib_empty", 64'(b32.out_valid), 64'd0);

        xfer(1'b0, 32'hFE20AE23, 3'b001, 64'hFFFFFFFC, 1'b0, "s32");
        xfer(1'b0, 32'h008000EF, 3'b011, 64'h00000008, 1'b0, "j32");
        xfer(1'b0, 32'h123450B7, 3'b100, 64'h12345000, 1'b0, "u32");
        xfer(1'b0, 32'hFFFFFFFF, 3'b111, 64'h0,        1'b1, "ill32");
        xfer(1'b1, 32'h800000B7, 3'b100, 64'hFFFFFFFF80000000, 1'b0, "u64");
        xfer(1'b1, 32'h03F01013, 3'b110, 64'd63, 1'b0, "sh64");
        xfer(1'b1, 32'h000F9073, 3'b101, 64'd31, 1'b0, "z64");
        xfer(1'b0, 32'h03F01013, 3'b110, 64'd31, 1'b0, "sh32");

        // Full: three back-to-back pushes with consumer stalled
        b32.in_valid = 1'b1; b32.in_instr = 32'h00100093; b32.in_func = 3'b000;
        step();
        chk("f1_cnt", 64'(b32.count), 64'd1);
        chk("f1_rdy", 64'(b32.in_ready), 64'd1);
        b32.in_instr = 32'h00200093;
        step();
        chk("f2_cnt", 64'(b32.count), 64'd2);
        chk("f2_rdy", 64'(b32.in_ready), 64'd0);
        b32.in_instr = 32'h00300093;
        step();
        chk("f3_held_cnt", 64'(b32.count), 64'd2);
        chk("f3_stable",   64'(b32.out_imm), 64'd1);
        b32.out_ready = 1'b1;
        step();
        chk("f4_cnt", 64'(b32.count), 64'd1);
        chk("f4_rdy", 64'(b32.in_ready), 64'd1);
        chk("f4_imm", 64'(b32.out_imm), 64'd2);
        step();
        b32.in_valid = 1'b0;
        chk("f5_cnt", 64'(b32.count), 64'd1);
        chk("f5_imm", 64'(b32.out_imm), 64'd3);
        step();
        b32.out_ready = 1'b0;
        chk("f6_empty", 64'(b32.out_valid), 64'd0);

        // Streaming push+pop each cycle; pointers wrap several times
        b32.in_valid = 1'b1; b32.out_ready = 1'b1; b32.in_func = 3'b000;
        for (int i = 1; i <= 10; i++) begin
            b32.in_instr = (32'(i) << 20) | 32'h13;
            step();
            chk($sformatf("str%0d_cnt", i), 64'(b32.count), 64'd1);
            chk($sformatf("str%0d_imm", i), 64'(b32.out_imm), 64'(i));
        end
        b32.in_valid = 1'b0;
        step();
        b32.out_ready = 1'b0;
        chk("str_drain", 64'(b32.count), 64'd0);

        // Asynchronous reset while holding two entries
        b32.in_valid = 1'b1; b32.in_instr = 32'h00500093;
        step();
        step();
        b32.in_valid = 1'b0;
        chk("ar_pre_cnt", 64'(b32.count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld", 64'(b32.out_valid), 64'd0);
        chk("ar_cnt", 64'(b32.count),     64'd0);
        chk("ar_rdy", 64'(b32.in_ready),  64'd1);
        chk("ar_imm", 64'(b32.out_imm),   64'd0);
        #2 rst_n = 1'b1;
        xfer(1'b0, 32'h00000000, 3'b111, 64'h0, 1'b1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
